// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, FSM states and default latencies for the MDU controller
package mdu_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_MADD  = 3'd7
   } mdu_op_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } mdu_state_e;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational HI/LO result generator; MADD accumulate present only with MDU_MADD_EN
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] div_s;
   logic [31:0] div_u;
   logic [31:0] sq;
   logic [31:0] sr;
   logic [31:0] uq;
   logic [31:0] ur;

   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};

      // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing
      mag_a  = a[31] ? (32'd0 - a) : a;
      mag_b  = b[31] ? (32'd0 - b) : b;
      div_s  = (b == 32'd0) ? 32'd1 : mag_b;
      div_u  = (b == 32'd0) ? 32'd1 : b;
      sq     = mag_a / div_s;
      sr     = mag_a % div_s;
      uq     = a / div_u;
      ur     = a % div_u;

      res_hi = hi;
      res_lo = lo;
      case (mdu_op_e'(op))
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            if (b != 32'd0) begin
               res_lo = (a[31] ^ b[31]) ? (32'd0 - sq) : sq;
               res_hi = a[31] ? (32'd0 - sr) : sr;
            end
         end
         OP_DIVU: begin
            if (b != 32'd0) begin
               res_lo = uq;
               res_hi = ur;
            end
         end
`ifdef MDU_MADD_EN
         OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
`endif
         default: ;
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit controller: IDLE/BUSY FSM, latency counter, HI/LO registers
// Define MDU_MADD_EN to accept op 7 (MADD); otherwise op 7 is a no-op.
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        req,
   input  logic        d_use_mdu,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;

   mdu_calc u_calc (
      .op     (op_q),
      .a      (a_q),
      .b      (b_q),
      .hi     (hi_q),
      .lo     (lo_q),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         S_IDLE: begin
            if (start && !req) begin
               case (mdu_op_e'(op))
                  OP_MULT, OP_MULTU: begin
                     state_d = S_BUSY;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_d = S_BUSY;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                  end
`ifdef MDU_MADD_EN
                  OP_MADD: begin
                     state_d = S_BUSY;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = op;
                     a_d     = a;
                     b_d     = b;
                  end
`endif
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            // HI/LO cannot change while busy, so MADD's accumulate base equals its value at issue
            if (cnt_q == CNT_W'(1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               hi_d    = res_hi;
               lo_d    = res_lo;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy  = (state_q == S_BUSY);
   assign stall = d_use_mdu & (busy | start);
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl: vector table plus multi-cycle corner sequences
module tb_mdu_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        req;
   logic        d_use_mdu;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   mdu_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .a         (a),
      .b         (b),
      .req       (req),
      .d_use_mdu (d_use_mdu),
      .busy      (busy),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      int          cycles;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
      op    = 3'd0;
   endtask

   task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
      issue(3'd5, h, 32'd0);
      issue(3'd6, l, 32'd0);
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 64) begin
         n++;
         tick();
      end
   endtask

   initial begin
      int n;
      int st;

      vecs[0]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
      vecs[1]  = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h0,  32'h0,        5,  32'h00000001, 32'hFFFFFFFE};
      vecs[2]  = '{3'd4, 32'd100,      32'd7,        32'h0,  32'h0,        10, 32'd2,        32'd14};
      vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h5,  32'h5,        10, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd3, 32'd55,       32'd0,        32'h11, 32'h22,       10, 32'h11,       32'h22};
      vecs[6]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,        10, 32'h00000001, 32'hFFFFFFFD};
      vecs[7]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h0,  32'h0,        5,  32'h40000000, 32'h00000000};
      vecs[8]  = '{3'd4, 32'd9,        32'd0,        32'h33, 32'h44,       10, 32'h33,       32'h44};
`ifdef MDU_MADD_EN
      vecs[9]  = '{3'd7, 32'd2,        32'd3,        32'h0,  32'hFFFFFFFF, 5,  32'h00000001, 32'h00000005};
`else
      vecs[9]  = '{3'd7, 32'd2,        32'd3,        32'h0,  32'hFFFFFFFF, 0,  32'h00000000, 32'hFFFFFFFF};
`endif
      vecs[10] = '{3'd0, 32'd2,        32'd3,        32'h9,  32'h8,        0,  32'h9,        32'h8};

      reset     = 1'b0;
      start     = 1'b0;
      op        = 3'd0;
      a         = 32'd0;
      b         = 32'd0;
      req       = 1'b0;
      d_use_mdu = 1'b0;
      tick();
      tick();
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         load_hilo(vecs[i].pre_hi, vecs[i].pre_lo);
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         wait_idle(n);
         check($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cycles));
         check($sformatf("vec%0d_hilo", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
      end

      // MTHI when idle lands on the next edge with busy kept low
      load_hilo(32'h0, 32'h0);
      issue(3'd5, 32'h1234, 32'd0);
      check("mthi_hi", {32'd0, hi}, 64'h1234);
      check("mthi_busy", {63'd0, busy}, 64'd0);

      // start with req high is discarded for both a multiply and a move
      load_hilo(32'hAA, 32'hBB);
      req = 1'b1;
      issue(3'd1, 32'd2, 32'd3);
      check("req_cancel_busy", {63'd0, busy}, 64'd0);
      issue(3'd5, 32'hDEAD, 32'd0);
      req = 1'b0;
      tick();
      check("req_cancel_hilo", {hi, lo}, {32'hAA, 32'hBB});

      // req pulse during BUSY does not cancel the operation
      issue(3'd1, 32'd2, 32'd3);
      tick();
      req = 1'b1;
      tick();
      req = 1'b0;
      wait_idle(n);
      check("req_busy_cycles", 64'(n + 2), 64'd5);
      check("req_busy_hilo", {hi, lo}, {32'h0, 32'h6});

      // start while busy (divide and MTHI) is ignored
      issue(3'd4, 32'd100, 32'd7);
      tick();
      tick();
      issue(3'd1, 32'd5, 32'd5);
      issue(3'd5, 32'hBEEF, 32'd0);
      wait_idle(n);
      check("busy_ignore_cycles", 64'(n + 4), 64'd10);
      check("busy_ignore_hilo", {hi, lo}, {32'd2, 32'd14});

      // stall tracks busy with decode holding an MDU instruction
      d_use_mdu = 1'b1;
      start     = 1'b1;
      op        = 3'd1;
      a         = 32'd1;
      b         = 32'd1;
      #1;
      check("stall_on_start", {63'd0, stall}, 64'd1);
      tick();
      start = 1'b0;
      op    = 3'd0;
      st    = 0;
      n     = 0;
      while (busy && n < 64) begin
         n++;
         if (stall) st++;
         tick();
      end
      check("stall_cycles", 64'(st), 64'd5);
      check("stall_after", {63'd0, stall}, 64'd0);
      d_use_mdu = 1'b0;

      // asynchronous reset in BUSY cycle 3 aborts the operation
      load_hilo(32'h77, 32'h66);
      issue(3'd1, 32'd4, 32'd4);
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      check("reset_mid_busy", {63'd0, busy}, 64'd0);
      check("reset_mid_hilo", {hi, lo}, 64'd0);
      tick();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check("reset_after_busy", {63'd0, busy}, 64'd0);
      check("reset_after_hilo", {hi, lo}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: BUSY duration for multiply-class ops.
REQ-002 Parameter DIV_CYCLES, default 10: BUSY duration for divide-class ops.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  issue strobe for op in this cycle.
REQ-006 op  input  3  operation code: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD.
REQ-007 a  input  32  operand rs.
REQ-008 b  input  32  operand rt.
REQ-009 req  input  1  exception/interrupt flush; cancels a same-cycle start.
REQ-010 d_use_mdu  input  1  decode stage holds an MDU-class instruction (incl. MFHI/MFLO).
REQ-011 busy  output  1  registered; high while an operation is in flight.
REQ-012 stall  output  1  combinational: d_use_mdu & (busy | start).
REQ-013 hi  output  32  HI register.
REQ-014 lo  output  32  LO register.

Function
REQ-015 SHALL implement two states: IDLE and BUSY.
REQ-016 IDLE -> BUSY on start & !req & op in {1,2,3,4,7 when enabled}; counter loads MULT_CYCLES (1,2,7) or DIV_CYCLES (3,4).
REQ-017 In BUSY, counter decrements each cycle; busy SHALL be high for exactly the loaded count of cycles, starting the cycle after start.
REQ-018 Result SHALL be computed from operands latched at start; HI/LO SHALL update on the edge where counter reaches 1, and busy falls on the same edge (BUSY -> IDLE).
REQ-019 MULT: {HI,LO} = signed 64-bit a*b; MULTU: unsigned 64-bit product.
REQ-020 DIV: LO = quotient truncated toward zero, HI = remainder with dividend's sign; DIVU: unsigned quotient/remainder.
REQ-021 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-022 Divide with b=0 SHALL still occupy DIV_CYCLES but leave HI/LO unchanged.
REQ-023 MTHI/MTLO with start & !req & !busy SHALL write a into HI/LO at the next edge; busy stays low.
REQ-024 start while busy SHALL be ignored (no state change); the issuing stage is stalled upstream.
REQ-025 req during BUSY SHALL NOT cancel the in-flight op; it completes and writes HI/LO.
REQ-026 start with req high SHALL be discarded entirely, for every op.
REQ-027 op 0 and undefined/disabled ops SHALL be no-ops.

Reset
REQ-028 reset low SHALL immediately force state IDLE, counter 0, busy 0, hi 0, lo 0, latched operands 0.
REQ-029 Reset mid-operation SHALL abort the op; no HI/LO write after reset release.

Configuration
REQ-030 With MDU_MADD_EN defined, op 7 MADD SHALL set {HI,LO} = {HI,LO} + signed a*b (value of HI/LO at issue, modulo 2^64), with MULT_CYCLES latency.
REQ-031 Without MDU_MADD_EN, op 7 SHALL be a no-op and SHALL NOT set busy.

Structure
REQ-032 Op codes, state encoding and default cycle counts SHALL reside in shared package mdu_pkg.
REQ-033 One sub-module, mdu_calc (combinational 64-bit product/quotient/remainder generator), is natural; the FSM, counter and HI/LO registers stay in mdu_ctrl.

Verification
REQ-034 MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 DIVU a=100, b=7 -> busy high 10 cycles, then LO=14, HI=2; DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 DIV b=0 with HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO remain 0x11/0x22.
REQ-037 MULT start with req=1 -> busy stays 0, HI/LO unchanged; req pulse at BUSY cycle 2 -> result still written.
REQ-038 d_use_mdu=1 with busy -> stall=1 every busy cycle, 0 after completion; MTHI a=0x1234 when idle -> HI=0x1234 next cycle.
REQ-039 reset low at BUSY cycle 3 -> busy, hi, lo read 0 immediately and stay 0 after release; with MDU_MADD_EN, MADD 2*3 onto HI=0, LO=0xFFFFFFFF -> HI=1, LO=5.
